// File: rtl/pkt_rr_arbiter_pkg.sv
// Shared types and helpers for the two-input packet round-robin arbiter.
package pkt_rr_arbiter_pkg;

  // Arbiter FSM: StIdle picks the next source, StXfer holds the grant until EOP.
  typedef enum logic {
    StIdle = 1'b0,
    StXfer = 1'b1
  } arb_state_e;

  // A word is EOP when it carries non-zero ctrl after at least one body word.
  function automatic logic is_eop(input logic ctrl_nonzero, input logic in_body);
    return ctrl_nonzero && in_body;
  endfunction

endpackage

// File: rtl/pkt_fwft_fifo.sv
// First-word-fall-through FIFO: the head word is visible on o_rdata whenever o_empty is low.
// o_rdy leaves one word of slack so an upstream writer reacting a cycle late is still absorbed.
module pkt_fwft_fifo #(
  parameter int unsigned WIDTH      = 72,
  parameter int unsigned DEPTH_BITS = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_rdy,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty
);

  localparam int unsigned Depth = 2 ** DEPTH_BITS;

  typedef logic [DEPTH_BITS-1:0] ptr_t;
  typedef logic [DEPTH_BITS:0]   cnt_t;

  localparam cnt_t CntFull   = cnt_t'(Depth);
  localparam cnt_t CntRdyMax = cnt_t'(Depth - 2);

  logic [WIDTH-1:0] r_mem [Depth];
  ptr_t             r_wr_ptr;
  ptr_t             r_rd_ptr;
  cnt_t             r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CntFull);
  assign o_empty = (r_count == '0);
  assign o_rdy   = (r_count <= CntRdyMax);
  // A write while full is dropped; a read while empty is ignored.
  assign w_push  = i_wr && !w_full;
  assign w_pop   = i_rd && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ptr_t'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + cnt_t'(1);
        2'b01:   r_count <= r_count - cnt_t'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Two-input packet arbiter: each input buffered in a FWFT FIFO, the output granted to one
// input for a whole packet, alternating round-robin at packet boundaries.
module pkt_rr_arbiter
  import pkt_rr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned FIFO_DEPTH_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data_0,
  input  logic [CTRL_WIDTH-1:0] in_ctrl_0,
  input  logic                  in_wr_0,
  output logic                  in_rdy_0,
  input  logic [DATA_WIDTH-1:0] in_data_1,
  input  logic [CTRL_WIDTH-1:0] in_ctrl_1,
  input  logic                  in_wr_1,
  output logic                  in_rdy_1,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  cur_grant
);

  localparam int unsigned WordWidth = DATA_WIDTH + CTRL_WIDTH;

  arb_state_e            r_state;
  logic                  r_cur_grant;
  logic                  r_in_body;
  logic                  r_out_wr;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [CTRL_WIDTH-1:0] r_out_ctrl;

  logic [WordWidth-1:0]  w_head_0;
  logic [WordWidth-1:0]  w_head_1;
  logic [WordWidth-1:0]  w_head;
  logic [1:0]            w_empty;
  logic [1:0]            w_pop;
  logic                  w_other;
  logic                  w_sel;
  logic                  w_avail;
  logic                  w_fire;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [CTRL_WIDTH-1:0] w_head_ctrl;
  logic                  w_ctrl_nz;
  logic                  w_eop;

  pkt_fwft_fifo #(
    .WIDTH      (WordWidth),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo_0 (
    .i_clk   (clk),
    .i_reset (reset),
    .i_wr    (in_wr_0),
    .i_wdata ({in_ctrl_0, in_data_0}),
    .o_rdy   (in_rdy_0),
    .i_rd    (w_pop[0]),
    .o_rdata (w_head_0),
    .o_empty (w_empty[0])
  );

  pkt_fwft_fifo #(
    .WIDTH      (WordWidth),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo_1 (
    .i_clk   (clk),
    .i_reset (reset),
    .i_wr    (in_wr_1),
    .i_wdata ({in_ctrl_1, in_data_1}),
    .o_rdy   (in_rdy_1),
    .i_rd    (w_pop[1]),
    .o_rdata (w_head_1),
    .o_empty (w_empty[1])
  );

  // Source selection: in idle the other input gets priority, mid-packet the grant is locked.
  always_comb begin
    w_other = ~r_cur_grant;
    w_sel   = r_cur_grant;
    w_avail = 1'b0;
    if (r_state == StIdle) begin
      if (!w_empty[w_other]) begin
        w_sel   = w_other;
        w_avail = 1'b1;
      end else if (!w_empty[r_cur_grant]) begin
        w_sel   = r_cur_grant;
        w_avail = 1'b1;
      end
    end else begin
      w_avail = !w_empty[r_cur_grant];
    end
    w_fire      = w_avail && out_rdy;
    w_pop       = 2'b00;
    w_pop[w_sel] = w_fire;
    w_head      = w_sel ? w_head_1 : w_head_0;
    w_head_data = w_head[DATA_WIDTH-1:0];
    w_head_ctrl = w_head[WordWidth-1 -: CTRL_WIDTH];
    w_ctrl_nz   = |w_head_ctrl;
    w_eop       = is_eop(w_ctrl_nz, r_in_body);
  end

  // Arbiter FSM with the registered output stage; grant, body tracking and state move on pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cur_grant <= 1'b1;
      r_in_body   <= 1'b0;
      r_out_wr    <= 1'b0;
      r_out_data  <= '0;
      r_out_ctrl  <= '0;
    end else begin
      r_out_wr <= w_fire;
      if (w_fire) begin
        r_out_data  <= w_head_data;
        r_out_ctrl  <= w_head_ctrl;
        r_cur_grant <= w_sel;
        if (w_eop) begin
          r_in_body <= 1'b0;
          r_state   <= StIdle;
        end else begin
          if (!w_ctrl_nz) r_in_body <= 1'b1;
          r_state <= StXfer;
        end
      end
    end
  end

  assign out_wr    = r_out_wr;
  assign out_data  = r_out_data;
  assign out_ctrl  = r_out_ctrl;
  assign cur_grant = r_cur_grant;

endmodule

// File: doc/pkt_rr_arbiter.md
Name: pkt_rr_arbiter

Overview:
Two-input, one-output packet arbiter for the user datapath stream interface (data/ctrl/wr/rdy).
- Each input is buffered in a small first-word-fall-through FIFO.
- The output is granted to one input for a whole packet, and grants alternate round-robin at packet boundaries.
- It sits ahead of a single-stream pipeline module and merges two sources, e.g. a CPU-injected stream and a MAC stream.
- It is not on the register ring.

Parameters:
DATA_WIDTH, 64, width of data words
CTRL_WIDTH, DATA_WIDTH/8, width of ctrl field
FIFO_DEPTH_BITS, 3, log2 of per-input FIFO depth (default depth 8)

Ports:
clk  in  1  single clock, all logic rising-edge
reset  in  1  synchronous active-high reset
in_data_0  in  DATA_WIDTH  input 0 data word
in_ctrl_0  in  CTRL_WIDTH  input 0 ctrl
in_wr_0  in  1  input 0 write strobe
in_rdy_0  out  1  input 0 may write
in_data_1  in  DATA_WIDTH  input 1 data word
in_ctrl_1  in  CTRL_WIDTH  input 1 ctrl
in_wr_1  in  1  input 1 write strobe
in_rdy_1  out  1  input 1 may write
out_data  out  DATA_WIDTH  registered output word
out_ctrl  out  CTRL_WIDTH  registered output ctrl
out_wr  out  1  registered output strobe
out_rdy  in  1  downstream may accept
cur_grant  out  1  input index currently or last granted

Behaviour:
Clock and reset: clk, synchronous active-high reset, as already decided.

Reset values:
- out_wr=0, out_data=0, out_ctrl=0, cur_grant=1 (so input 0 wins first).
- FIFOs empty; in_rdy_0=in_rdy_1=1.
- FSM=IDLE; in_body=0.

Packet format:
- One or more header words (ctrl!=0), then one or more body words (ctrl==0).
- The last word is the first word with ctrl!=0 after a body word; this is EOP.
- in_body flag: set on popping a ctrl==0 word; cleared on popping EOP.

Input FIFOs:
- A write when in_wr_i=1 at an edge is stored.
- in_rdy_i = (occupancy <= DEPTH-2), giving one word of slack.
- A write with the FIFO full is discarded; the FIFO is unchanged.

Output pop rule:
- At an edge, if the granted FIFO is non-empty and out_rdy=1, pop its head into out_data/out_ctrl and set out_wr=1 for the next cycle.
- Otherwise out_wr=0 next cycle; out_data/out_ctrl hold their last value.

FSM IDLE:
- Pick the candidate: the input != cur_grant if its FIFO is non-empty, else cur_grant if its FIFO is non-empty.
- If a candidate exists and out_rdy=1: set cur_grant=candidate, pop the first word, go XFER.
- If the popped word is EOP, which is only possible with in_body already set, stay IDLE.

FSM XFER:
- Pop from cur_grant per the pop rule.
- On popping EOP, go IDLE.
- The next edge can pop the next packet, so there are no bubble cycles between back-to-back packets.

Latency:
- A word written at edge N into an empty FIFO, with an idle arbiter and out_rdy=1, is popped at edge N+1.
- out_wr is high during cycle N+1..N+2.

Simultaneous events:
- Push and pop on the same FIFO at the same edge: both take effect, occupancy unchanged.
- A write to the non-granted input during XFER is buffered only, never interleaved.

Flow control:
- out_rdy=0 stalls mid-packet; the grant is held indefinitely.
- Words are never reordered or dropped, except writes when full.

Reset mid-packet:
- FIFOs flush and the FSM returns to IDLE.
- The partial packet is lost; upstream shares the same reset.

Decomposition:
- Shared package/defines: FSM state encodings (IDLE, XFER) and an EOP-detect helper function (ctrl!=0 && in_body).
- Sub-module: pkt_fwft_fifo (DATA_WIDTH+CTRL_WIDTH wide, 2**FIFO_DEPTH_BITS deep), instantiated twice.
- The arbiter FSM, round-robin pointer and output register live in the top module.

Test Plan:
- Single packet on input 0 (H=0xFF, B1, B2 ctrl=0, EOP ctrl=0x80), out_rdy=1 -> four consecutive out_wr words, identical values, first out_wr one edge after the first write; cur_grant=0.
- Both inputs each hold a 3-word packet from reset -> output order is input 0 packet then input 1 packet, no interleave, no bubble between them; cur_grant 0 then 1.
- Input 1 streams packets continuously, and input 0 injects one packet mid-packet-1 -> input 0's packet follows the current input 1 packet, then grant returns to 1.
- out_rdy held 0 for 5 cycles mid-packet -> out_wr=0 those cycles, no word lost, remaining words resume in order.
- Fill input 0 with out_rdy=0 -> in_rdy_0 drops at occupancy 7; an extra write at full (8) is discarded and only 8 words emerge.
- Assert reset mid-packet -> next cycle out_wr=0, in_rdy both 1, cur_grant=1; a new packet afterward is forwarded intact.
